// File: rtl/lcd_init_ahb_master.sv
// AHB-Lite master that writes a fixed HD44780 init sequence into an LCD config block.
// Define LCD_INIT_READBACK_EN to read back and verify every instruction write.
module lcd_init_ahb_master #(
  parameter logic [15:0] PRESCALER_VAL    = 16'd10,
  parameter logic [15:0] GAP_CYCLES       = 16'd4000,
  parameter logic [15:0] CLEAR_GAP_CYCLES = 16'd20000,
  parameter logic [11:0] CTRL_ADDR        = 12'h000,
  parameter logic [11:0] INSTR_ADDR       = 12'h004,
  parameter logic [11:0] PRESCALER_ADDR   = 12'h00C
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic [11:0] haddr_o,
  output logic [31:0] hwdata_o,
  output logic        hwrite_o,
  output logic [1:0]  htrans_o,
  input  logic [31:0] hrdata_i,
  input  logic        hready_i,
  input  logic        hresp_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] LAST_STEP     = 3'd6;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StGap,
`ifdef LCD_INIT_READBACK_EN
    StRdbkAddr,
    StRdbkData,
`endif
    StDone,
    StErr
  } state_e;

  state_e      r_state, w_state_next;
  logic [2:0]  r_step, w_step_next;
  logic [15:0] r_cnt, w_cnt_next;
  logic        r_done, w_done_next;
  logic        r_error, w_error_next;
  logic [11:0] r_haddr;
  logic [31:0] r_hwdata;
  logic        r_hwrite;
  logic        w_load_step;
  logic        w_load_rdbk;
  logic [15:0] w_gap;
  logic        w_gap_end;

  function automatic logic [11:0] step_addr(input logic [2:0] step);
    case (step)
      3'd0:    return PRESCALER_ADDR;
      3'd1:    return CTRL_ADDR;
      default: return INSTR_ADDR;
    endcase
  endfunction

  function automatic logic [31:0] step_data(input logic [2:0] step);
    case (step)
      3'd0:    return {16'h0000, PRESCALER_VAL};
      3'd1:    return 32'h0000_0001;
      3'd2:    return 32'h0000_0030;
      3'd3:    return 32'h0000_0038;
      3'd4:    return 32'h0000_000C;
      3'd5:    return 32'h0000_0001;
      default: return 32'h0000_0006;
    endcase
  endfunction

  // Clear-display needs the long settle time; every other instruction uses the short gap.
  assign w_gap     = ((r_step >= 3'd2) && (step_data(r_step) == 32'h0000_0001)) ?
                     CLEAR_GAP_CYCLES : GAP_CYCLES;
  assign w_gap_end = ({1'b0, r_cnt} + 17'd1) >= {1'b0, w_gap};

`ifdef LCD_INIT_READBACK_EN
  logic w_unused_hrdata;
  assign w_unused_hrdata = ^hrdata_i[31:10];
`else
  logic w_unused_hrdata;
  assign w_unused_hrdata = ^hrdata_i;
`endif

  always_comb begin
    w_state_next = r_state;
    w_step_next  = r_step;
    w_cnt_next   = r_cnt;
    w_done_next  = r_done;
    w_error_next = r_error;
    w_load_step  = 1'b0;
    w_load_rdbk  = 1'b0;
    unique case (r_state)
      StIdle, StDone, StErr: begin
        if (start_i) begin
          w_state_next = StAddr;
          w_step_next  = 3'd0;
          w_cnt_next   = 16'd0;
          w_done_next  = 1'b0;
          w_error_next = 1'b0;
          w_load_step  = 1'b1;
        end
      end
      StAddr: begin
        if (hready_i) w_state_next = StData;
      end
      StData: begin
        if (hresp_i) begin
          w_state_next = StErr;
          w_error_next = 1'b1;
        end else if (hready_i) begin
          if (r_step < 3'd2) begin
            w_state_next = StAddr;
            w_step_next  = r_step + 3'd1;
            w_load_step  = 1'b1;
          end else begin
`ifdef LCD_INIT_READBACK_EN
            w_state_next = StRdbkAddr;
            w_load_rdbk  = 1'b1;
`else
            w_state_next = StGap;
            w_cnt_next   = 16'd0;
`endif
          end
        end
      end
`ifdef LCD_INIT_READBACK_EN
      StRdbkAddr: begin
        if (hready_i) w_state_next = StRdbkData;
      end
      StRdbkData: begin
        if (hresp_i) begin
          w_state_next = StErr;
          w_error_next = 1'b1;
        end else if (hready_i) begin
          if (hrdata_i[9:0] == r_hwdata[9:0]) begin
            w_state_next = StGap;
            w_cnt_next   = 16'd0;
          end else begin
            w_state_next = StErr;
            w_error_next = 1'b1;
          end
        end
      end
`endif
      StGap: begin
        if (w_gap_end) begin
          w_cnt_next = 16'd0;
          if (r_step == LAST_STEP) begin
            w_state_next = StDone;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = StAddr;
            w_step_next  = r_step + 3'd1;
            w_load_step  = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= StIdle;
      r_step   <= 3'd0;
      r_cnt    <= 16'd0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_haddr  <= 12'h000;
      r_hwdata <= 32'h0000_0000;
      r_hwrite <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_step  <= w_step_next;
      r_cnt   <= w_cnt_next;
      r_done  <= w_done_next;
      r_error <= w_error_next;
      // hwdata keeps the written value through readback so it can be compared.
      if (w_load_step) begin
        r_haddr  <= step_addr(w_step_next);
        r_hwdata <= step_data(w_step_next);
        r_hwrite <= 1'b1;
      end else if (w_load_rdbk) begin
        r_haddr  <= INSTR_ADDR;
        r_hwrite <= 1'b0;
      end
    end
  end

  always_comb begin
    htrans_o = HTRANS_IDLE;
    busy_o   = 1'b0;
    unique case (r_state)
      StAddr: begin
        htrans_o = HTRANS_NONSEQ;
        busy_o   = 1'b1;
      end
      StData, StGap: busy_o = 1'b1;
`ifdef LCD_INIT_READBACK_EN
      StRdbkAddr: begin
        htrans_o = HTRANS_NONSEQ;
        busy_o   = 1'b1;
      end
      StRdbkData: busy_o = 1'b1;
`endif
      default: ;
    endcase
  end

  assign haddr_o  = r_haddr;
  assign hwdata_o = r_hwdata;
  assign hwrite_o = r_hwrite;
  assign done_o   = r_done;
  assign error_o  = r_error;

endmodule

// File: tb/tb_lcd_init_ahb_master.sv
// Directed bench for lcd_init_ahb_master with a logging AHB-Lite slave model.
module tb_lcd_init_ahb_master;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [11:0] haddr_o;
  logic [31:0] hwdata_o;
  logic        hwrite_o;
  logic [1:0]  htrans_o;
  logic [31:0] hrdata_i;
  logic        hready_i;
  logic        hresp_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  int checks   = 0;
  int failures = 0;

`ifdef LCD_INIT_READBACK_EN
  localparam int BusyCycles = 48;
`else
  localparam int BusyCycles = 38;
`endif

  logic [11:0] exp_addr [7] = '{12'h00C, 12'h000, 12'h004, 12'h004, 12'h004, 12'h004, 12'h004};
  logic [31:0] exp_data [7] = '{32'h00A, 32'h001, 32'h030, 32'h038, 32'h00C, 32'h001, 32'h006};

  lcd_init_ahb_master #(
    .GAP_CYCLES      (16'd4),
    .CLEAR_GAP_CYCLES(16'd8)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .haddr_o (haddr_o),
    .hwdata_o(hwdata_o),
    .hwrite_o(hwrite_o),
    .htrans_o(htrans_o),
    .hrdata_i(hrdata_i),
    .hready_i(hready_i),
    .hresp_i (hresp_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .error_o (error_o)
  );

  always #5 clk_i = ~clk_i;

  // Slave model: logs completed writes, counts reads and NONSEQ, echoes the last instruction.
  logic [11:0] wr_addr [$];
  logic [31:0] wr_data [$];
  int          nonseq_cnt = 0;
  int          rd_cnt     = 0;
  logic        pend_v     = 1'b0;
  logic        pend_w     = 1'b0;
  logic [11:0] pend_a     = 12'h000;
  logic [31:0] last_instr = 32'h0;
  logic        corrupt;

  assign hrdata_i = corrupt ? 32'h0 : last_instr;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      pend_v <= 1'b0;
    end else if (hready_i) begin
      if (pend_v) begin
        if (pend_w) begin
          wr_addr.push_back(pend_a);
          wr_data.push_back(hwdata_o);
          if (pend_a == 12'h004) last_instr <= hwdata_o;
        end else begin
          rd_cnt <= rd_cnt + 1;
        end
      end
      pend_v <= (htrans_o == 2'b10);
      pend_a <= haddr_o;
      pend_w <= hwrite_o;
      if (htrans_o == 2'b10) nonseq_cnt <= nonseq_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o && n < 1000) begin
      tick();
      n++;
    end
    check_eq({tag, "_idle"}, 64'(busy_o), 64'd0);
  endtask

  task automatic check_log(input string tag, input int base);
    check_eq({tag, "_nwr"}, 64'(wr_addr.size() - base), 64'd7);
    for (int i = 0; i < 7; i++) begin
      if (base + i < wr_addr.size())
        check_eq($sformatf("%s_wr%0d", tag, i), {wr_addr[base + i], wr_data[base + i]},
                 {exp_addr[i], exp_data[i]});
    end
  endtask

  initial begin
    int base;
    int nbase;
    int rbase;
    int n;

    rst_ni   = 1'b0;
    start_i  = 1'b0;
    hready_i = 1'b1;
    hresp_i  = 1'b0;
    corrupt  = 1'b0;
    #12;
    check_eq("reset_outs", {htrans_o, haddr_o, hwdata_o, hwrite_o, busy_o, done_o, error_o},
             64'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    tick();
    check_eq("idle_after_rst", {htrans_o, busy_o}, 64'd0);

    // Full sequence with no wait states; busy length pins down every gap.
    base  = wr_addr.size();
    rbase = rd_cnt;
    pulse_start();
    n = 0;
    while (busy_o && n < 500) begin
      n++;
      tick();
    end
    check_eq("busy_cycles", 64'(n), 64'(BusyCycles));
    check_eq("run1_status", {done_o, error_o, busy_o, htrans_o}, {1'b1, 1'b0, 1'b0, 2'b00});
    check_log("run1", base);
`ifdef LCD_INIT_READBACK_EN
    check_eq("run1_reads", 64'(rd_cnt - rbase), 64'd5);
`endif

    // Wait states in step 2 data phase plus an ignored start pulse.
    base  = wr_addr.size();
    nbase = nonseq_cnt;
    pulse_start();
    n = 0;
    while (!(htrans_o == 2'b10 && haddr_o == 12'h004) && n < 100) begin
      tick();
      n++;
    end
    check_eq("step2_addr_seen", 64'(n < 100), 64'd1);
    tick();
    hready_i = 1'b0;
    start_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_eq($sformatf("stall_hwdata%0d", i), {htrans_o, hwdata_o}, {2'b00, 32'h030});
      tick();
      start_i = 1'b0;
    end
    hready_i = 1'b1;
    check_eq("stall_nonseq", 64'(nonseq_cnt - nbase), 64'd3);
    wait_idle("run2");
    check_eq("run2_status", {done_o, error_o}, 64'b10);
    check_log("run2", base);

    // Error response on step 4.
    nbase = nonseq_cnt;
    pulse_start();
    n = 0;
    while (!(htrans_o == 2'b10 && nonseq_cnt - nbase == 4) && n < 100) begin
      tick();
      n++;
    end
    check_eq("step4_addr_seen", 64'(n < 100), 64'd1);
    tick();
    hresp_i  = 1'b1;
    hready_i = 1'b0;
    tick();
    hready_i = 1'b1;
    tick();
    hresp_i = 1'b0;
    check_eq("err_status", {error_o, done_o, busy_o, htrans_o}, {1'b1, 1'b0, 1'b0, 2'b00});
    repeat (10) tick();
    check_eq("err_no_nonseq", 64'(nonseq_cnt - nbase), 64'd5);
    check_eq("err_addr_held", 64'(haddr_o), 64'h004);

    // Restart after error clears the flag and reruns everything.
    base = wr_addr.size();
    pulse_start();
    @(negedge clk_i);
    check_eq("restart_clears", {error_o, done_o, busy_o}, 64'b001);
    wait_idle("run3");
    check_eq("run3_status", {done_o, error_o}, 64'b10);
    check_log("run3", base);

    // Asynchronous reset in the gap after step 3.
    base = wr_addr.size();
    pulse_start();
    n = 0;
    while (wr_addr.size() - base < 4 && n < 200) begin
      tick();
      n++;
    end
    check_eq("step3_done_seen", 64'(n < 200), 64'd1);
    tick();
    rst_ni = 1'b0;
    #1;
    check_eq("async_rst_outs", {htrans_o, haddr_o, hwdata_o, hwrite_o, busy_o, done_o, error_o},
             64'd0);
    tick();
    rst_ni = 1'b1;
    repeat (5) tick();
    check_eq("stay_idle", {htrans_o, busy_o, done_o}, 64'd0);
    base = wr_addr.size();
    pulse_start();
    wait_idle("run4");
    check_eq("run4_status", {done_o, error_o}, 64'b10);
    check_log("run4", base);

`ifdef LCD_INIT_READBACK_EN
    // Bad readback of 0x038.
    base = wr_addr.size();
    pulse_start();
    n = 0;
    while (wr_addr.size() - base < 4 && n < 200) begin
      tick();
      n++;
    end
    corrupt = 1'b1;
    wait_idle("rdbk_bad");
    corrupt = 1'b0;
    check_eq("rdbk_bad_status", {error_o, done_o}, 64'b10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
